// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: adds two WIDTH-bit operands plus carry-in, one bit per cycle LSB first,
// through a single full-adder slice, behind a start/done handshake.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] a_sh, b_sh, sum_sh, sum_nx;
  logic [CW-1:0] cnt;
  logic carry, fa_sum, fa_carry, accept, last;
  assign fa_sum   = a_sh[0] ^ b_sh[0] ^ carry;
  assign fa_carry = (a_sh[0] & b_sh[0]) | (carry & (a_sh[0] ^ b_sh[0]));
  // concatenate-then-shift keeps the MSB insert legal even when WIDTH is 1
  assign sum_nx   = WIDTH'({fa_sum, sum_sh} >> 1);
  assign last     = cnt == CW'(WIDTH - 1);
  assign accept   = start && state != SHIFT;
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nx;
  always_comb
    state_nx = state == SHIFT ? (last ? DONE : SHIFT) : (start ? SHIFT : IDLE);
  always_comb begin
    busy = state == SHIFT;
    done = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      carry <= cin;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      sum_sh <= sum_nx;
      carry  <= fa_carry;
      cnt    <= cnt + CW'(1);
      if (last) begin
        sum  <= sum_nx;
        cout <= fa_carry;
      end
    end
  end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed and random checks of the bit-serial adder at WIDTH=8 and WIDTH=1
module tb_serial_adder_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic start8 = 1'b0, cin8 = 1'b0, busy8, done8, cout8;
  logic [7:0] a8 = '0, b8 = '0, sum8;
  logic start1 = 1'b0, a1 = 1'b0, b1 = 1'b0, cin1 = 1'b0, busy1, done1, sum1, cout1;
  int n_checks = 0, n_fail = 0, cyc = 0, done_cnt8 = 0;
  bit overlap = 1'b0, stray_done = 1'b0;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
    .cin(cin8), .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_adder_ctrl #(.WIDTH(1)) dut1 (.clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .cin(cin1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1));

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    if (done8 && !rst) done_cnt8++;
    if ((busy8 && done8) || (busy1 && done1)) overlap = 1'b1;
  end

  typedef struct {
    logic [7:0] a, b;
    logic cin;
    logic [7:0] s;
    logic co;
  } vec_t;
  vec_t tbl[7];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done8(output int lat);
    lat = 0;
    while (!done8 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec, input string name);
    int lat;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk({name, "_busy"}, busy8, 1'b1);
    wait_done8(lat);
    chk({name, "_lat"}, lat + 1, 9);
    chk({name, "_sum"}, sum8, es);
    chk({name, "_cout"}, cout8, ec);
  endtask

  initial begin
    int lat, t1, t2, accepted, d0;
    logic [8:0] full;
    logic [1:0] tt1[8];
    tbl[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    tbl[3] = '{8'h01, 8'h01, 1'b0, 8'h02, 1'b0};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    tbl[5] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
    tbl[6] = '{8'h12, 8'h34, 1'b1, 8'h47, 1'b0};
    tt1 = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    tick(); tick();
    rst = 1'b0;
    chk("rst_busy8", busy8, 1'b0);
    chk("rst_done8", done8, 1'b0);
    chk("rst_sum8", sum8, 8'h00);
    chk("rst_cout8", cout8, 1'b0);
    chk("rst_busy1", busy1, 1'b0);
    chk("rst_sum1", {cout1, sum1}, 2'b00);

    for (int i = 0; i < 7; i++) begin
      run8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].s, tbl[i].co, $sformatf("tbl%0d", i));
      tick();
    end

    // back-to-back: start held through DONE
    a8 = 8'hFF; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1;
    wait_done8(lat);
    t1 = cyc;
    chk("b2b1_sum", sum8, 8'h00);
    chk("b2b1_cout", cout8, 1'b1);
    tick();
    start8 = 1'b0;
    chk("b2b2_busy", busy8, 1'b1);
    wait_done8(lat);
    t2 = cyc;
    chk("b2b_gap", t2 - t1, 9);
    chk("b2b2_sum", sum8, 8'hFF);
    chk("b2b2_cout", cout8, 1'b1);
    tick();

    // start during SHIFT is ignored; previous result stays visible
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("ign_hold_sum", sum8, 8'hFF);
    chk("ign_hold_busy", busy8, 1'b1);
    wait_done8(lat);
    chk("ign_sum", sum8, 8'h30);
    chk("ign_cout", cout8, 1'b0);
    tick();

    // reset mid-operation
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_busy", busy8, 1'b0);
    chk("mid_rst_done", done8, 1'b0);
    chk("mid_rst_sum", sum8, 8'h00);
    chk("mid_rst_cout", cout8, 1'b0);
    for (int i = 0; i < 12; i++) begin
      if (done8) stray_done = 1'b1;
      tick();
    end
    chk("mid_rst_no_done", stray_done, 1'b0);
    run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "post_rst");
    tick();

    // WIDTH=1 truth table
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; cin1 = i[0]; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      chk($sformatf("w1_%0d_busy", i), busy1, 1'b1);
      tick();
      chk($sformatf("w1_%0d_done", i), done1, 1'b1);
      chk($sformatf("w1_%0d_res", i), {cout1, sum1}, tt1[i]);
      tick();
    end

    // random operations with idle gaps
    accepted = 0;
    d0 = done_cnt8;
    for (int i = 0; i < 1000; i++) begin
      a8 = 8'($urandom); b8 = 8'($urandom); cin8 = 1'($urandom);
      full = {1'b0, a8} + {1'b0, b8} + {8'h00, cin8};
      run8(a8, b8, cin8, full[7:0], full[8], "rnd");
      accepted++;
      tick();
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
    end
    chk("rnd_done_count", done_cnt8 - d0, accepted);
    chk("busy_done_overlap", overlap, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end
endmodule
